uart_rx_byte: RTL and testbench



---
 rtl/uart_rx_byte_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx_byte.sv | 146 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the 8N1 UART byte receiver: state encoding, frame constants
// and the bit-period calculation (returns 0 for rates too fast to oversample by 8).
package uart_rx_byte_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        int cpb;
        cpb = clk_hz / baud;
        return (cpb >= 8) ? cpb : 0;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; idles/resets high.
// Latency 2 cycles, no flow control.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: one-cycle VALID per good frame, FERR per bad stop bit; no ready (sink never stalls).
// ~CLKS_PER_BIT*9.5+3 cycles from start edge to VALID; UART_RX_MAJORITY_EN enables 3-sample voting.
module uart_rx_byte #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FERR,
    output logic       BUSY
);
    import uart_rx_byte_pkg::*;

    localparam int CLKS_PER_BIT = uart_rx_byte_pkg::calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int TW           = $clog2(CLKS_PER_BIT) + 1;

    generate
        if (CLKS_PER_BIT == 0) begin : g_bad_rate
            $error("uart_rx_byte: CLK_HZ/BAUD must be at least 8");
        end
    endgenerate

    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic rxs;
    logic sample;

    uart_rx_sync u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (RXD),
        .q   (rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two past samples plus the current rxs form the three-sample voting window.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[0], rxs};
        sample = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) hist_q <= 2'b11;
        else     hist_q <= hist_d;
    end
`else
    assign sample = rxs;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          expire;

    assign expire = (tick_q == '0);

    always_comb begin
        state_d  = state_q;
        tick_d   = expire ? tick_q : tick_q - TW'(1);
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    tick_d  = HALF_LOAD;
                end
            end
            START: begin
                if (expire) begin
                    if (!sample) begin
                        state_d  = uart_rx_byte_pkg::DATA;
                        tick_d   = BIT_LOAD;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            uart_rx_byte_pkg::DATA: begin
                if (expire) begin
                    shreg_d  = {sample, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    tick_d   = BIT_LOAD;
                    if (bitcnt_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit gives half a bit of slack for the next start edge.
                if (expire) begin
                    if (sample == STOP_LEVEL) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bitcnt_q <= 3'd0;
            shreg_q  <= 8'd0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end

    assign DATA  = data_q;
    assign VALID = valid_q;
    assign FERR  = ferr_q;
    assign BUSY  = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit: table of single frames plus
// hand sequences for back-to-back frames, a short start glitch and mid-frame reset.
module tb_uart_rx_byte;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic [7:0] DATA;
    logic       VALID;
    logic       FERR;
    logic       BUSY;

    uart_rx_byte #(.CLK_HZ(16000000), .BAUD(1000000)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .RXD   (RXD),
        .DATA  (DATA),
        .VALID (VALID),
        .FERR  (FERR),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    localparam int PERIOD = 10;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] GLITCH_EXP = 8'hC3;
`else
    localparam logic [7:0] GLITCH_EXP = 8'hC7;
`endif

    // Output monitor, sampled on the falling edge.
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         proto_err = 0;
    time        valid_times[$];
    logic [7:0] valid_data[$];
    logic       prev_v = 1'b0, prev_f = 1'b0, prev_busy = 1'b0, prev2_busy = 1'b0;
    logic       busy_2before = 1'b0, busy_after = 1'b1, after_pending = 1'b0;

    always @(negedge CLK) begin
        if (after_pending) begin
            busy_after    = BUSY;
            after_pending = 1'b0;
        end
        if (VALID && FERR) proto_err++;
        if ((VALID && prev_v) || (FERR && prev_f)) proto_err++;
        if (VALID) begin
            valid_cnt++;
            valid_times.push_back($time);
            valid_data.push_back(DATA);
            busy_2before  = prev2_busy;
            after_pending = 1'b1;
        end
        if (FERR) ferr_cnt++;
        prev_v     = VALID;
        prev_f     = FERR;
        prev2_busy = prev_busy;
        prev_busy  = BUSY;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    time bit_t0;

    task automatic send_bit(input logic v, input int glitch_at);
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            if (c == 0) bit_t0 = $time;
            RXD = (c == glitch_at) ? ~v : v;
        end
    endtask

    // Cycle 8 of a bit window lines up with the receiver's mid-bit sample.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit,
                              output time t_start);
        send_bit(1'b0, -1);
        t_start = bit_t0;
        for (int i = 0; i < 8; i++) send_bit(d[i], (i == glitch_bit) ? 8 : -1);
        send_bit(stop, -1);
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        RXD = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    typedef struct {
        logic [7:0] din;
        logic       stop;
        int         glitch_bit;
        int         hold_low;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  v0, f0, n0, k;
        time t0;
        vecs[0] = '{8'hA5, 1'b1, -1, 0,  8'hA5, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, -1, 40, 8'hA5, 0, 1};
        vecs[2] = '{8'h81, 1'b1, -1, 0,  8'h81, 1, 0};
        vecs[3] = '{8'hC3, 1'b1, 2,  0,  GLITCH_EXP, 1, 0};

        repeat (3) @(negedge CLK);
        chk("reset DATA", int'(DATA), 0);
        chk("reset VALID", int'(VALID), 0);
        chk("reset FERR", int'(FERR), 0);
        chk("reset BUSY", int'(BUSY), 0);
        RST = 1'b0;
        idle(10);

        for (int i = 0; i < 4; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].din, vecs[i].stop, vecs[i].glitch_bit, t0);
            repeat (vecs[i].hold_low) @(negedge CLK);
            idle(30);
            chk($sformatf("vec%0d VALID count", i), valid_cnt - v0, vecs[i].exp_valid);
            chk($sformatf("vec%0d FERR count", i), ferr_cnt - f0, vecs[i].exp_ferr);
            chk($sformatf("vec%0d DATA", i), int'(DATA), int'(vecs[i].exp_data));
            if (vecs[i].exp_valid == 1 && valid_cnt - v0 == 1) begin
                chk_rng($sformatf("vec%0d latency", i),
                        int'((valid_times[$] - t0) / PERIOD), 154, 156);
                chk($sformatf("vec%0d BUSY 2 before VALID", i), int'(busy_2before), 1);
                chk($sformatf("vec%0d BUSY after VALID", i), int'(busy_after), 0);
            end
        end

        // Back-to-back frames with no idle gap.
        v0 = valid_cnt;
        n0 = valid_times.size();
        send_frame(8'h00, 1'b1, -1, t0);
        send_frame(8'hFF, 1'b1, -1, t0);
        send_frame(8'h5A, 1'b1, -1, t0);
        idle(30);
        chk("b2b VALID count", valid_cnt - v0, 3);
        if (valid_cnt - v0 == 3) begin
            chk("b2b DATA0", int'(valid_data[n0]), 8'h00);
            chk("b2b DATA1", int'(valid_data[n0+1]), 8'hFF);
            chk("b2b DATA2", int'(valid_data[n0+2]), 8'h5A);
            chk_rng("b2b spacing01", int'((valid_times[n0+1] - valid_times[n0]) / PERIOD), 159, 161);
            chk_rng("b2b spacing12", int'((valid_times[n0+2] - valid_times[n0+1]) / PERIOD), 159, 161);
        end

        // Four-cycle low pulse is rejected at the mid-start check.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        @(negedge CLK);
        RXD = 1'b0;
        repeat (4) @(negedge CLK);
        RXD = 1'b1;
        chk("glitch BUSY raised", int'(BUSY), 1);
        k = 0;
        while (BUSY && k < 12) begin
            @(negedge CLK);
            k++;
        end
        chk("glitch BUSY low in 12", int'(BUSY), 0);
        idle(20);
        chk("glitch VALID count", valid_cnt - v0, 0);
        chk("glitch FERR count", ferr_cnt - f0, 0);

        // Asynchronous reset in the middle of data bit 4 of 0x77.
        send_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h77 >> i), -1);
        repeat (8) @(negedge CLK);
        chk("midframe BUSY", int'(BUSY), 1);
        #2 RST = 1'b1;
        #1;
        chk("abort DATA", int'(DATA), 0);
        chk("abort VALID", int'(VALID), 0);
        chk("abort FERR", int'(FERR), 0);
        chk("abort BUSY", int'(BUSY), 0);
        RXD = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        idle(20);
        v0 = valid_cnt;
        send_frame(8'h12, 1'b1, -1, t0);
        idle(30);
        chk("post-reset VALID count", valid_cnt - v0, 1);
        chk("post-reset DATA", int'(DATA), 8'h12);

        chk("VALID/FERR pulse rules", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
